gray_conv_pipe: RTL



---
 rtl/gray_conv_pkg.sv | 33 +++
 rtl/gray_conv_stage.sv | 40 ++++
 rtl/gray_conv_pipe.sv | 83 ++++++++
 3 files changed

// File: rtl/gray_conv_pkg.sv
// Shared mode encodings and Gray-code helpers for the gray_conv_pipe slice.
// Helpers take 32-bit operands; callers zero-extend narrower words.
package gray_conv_pkg;

  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;
  localparam int   MAX_W    = 32;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero-extended upper bits leave it exact.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] r;
    r = '0;
    r[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      r[i] = r[i+1] ^ g[i];
    end
    return r;
  endfunction

  function automatic logic [5:0] popcount(input logic [MAX_W-1:0] v);
    logic [5:0] c;
    c = 6'd0;
    for (int i = 0; i < MAX_W; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/gray_conv_stage.sv
// One valid/ready register slice; loads whenever empty or draining so
// bubbles collapse even while downstream is stalled.
module gray_conv_stage
  import gray_conv_pkg::*;
#(
  parameter int DW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          r_valid;
  logic [DW-1:0] r_data;
  logic          w_load;

  assign w_load    = !r_valid || out_ready;
  assign in_ready  = w_load;
  assign out_valid = r_valid;
  assign out_data  = r_data;

  // Data is only captured with a valid word so idle X inputs never enter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/gray_conv_pipe.sv
// Pipelined binary<->Gray converter with per-transaction mode.
// Optional GRAY_ADJ_CHK_EN adds adj_err, flagging non-unit-step Gray output.
module gray_conv_pipe
  import gray_conv_pkg::*;
#(
  parameter int W      = 5,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_mode,
  output logic [W-1:0] out_data
`ifdef GRAY_ADJ_CHK_EN
  ,
  output logic         adj_err
`endif
);

  logic         w_valid [0:STAGES];
  logic         w_ready [0:STAGES];
  logic [W:0]   w_data  [0:STAGES];
  logic [W-1:0] w_conv;

  always_comb begin
    if (in_mode == MODE_G2B) begin
      w_conv = W'(gray2bin(32'(in_data)));
    end else begin
      w_conv = W'(bin2gray(32'(in_data)));
    end
  end

  assign w_valid[0]      = in_valid;
  assign w_data[0]       = {in_mode, w_conv};
  assign w_ready[STAGES] = out_ready;
  assign in_ready        = w_ready[0] && !rst;

  generate
    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
      gray_conv_stage #(.DW(W + 1)) u_stage (
        .clk      (clk),
        .rst      (rst),
        .in_valid (w_valid[k-1]),
        .in_ready (w_ready[k-1]),
        .in_data  (w_data[k-1]),
        .out_valid(w_valid[k]),
        .out_ready(w_ready[k]),
        .out_data (w_data[k])
      );
    end
  endgenerate

  assign out_valid = w_valid[STAGES];
  assign out_mode  = w_data[STAGES][W];
  assign out_data  = w_data[STAGES][W-1:0];

`ifdef GRAY_ADJ_CHK_EN
  logic [W-1:0] r_last_gray;
  logic         r_seen_gray;
  logic         w_b2g_xfer;

  assign w_b2g_xfer = out_valid && out_ready && (out_mode == MODE_B2G);
  assign adj_err    = w_b2g_xfer && r_seen_gray &&
                      (popcount(32'(out_data ^ r_last_gray)) > 6'd1);

  // Track the last emitted Gray word; G2B traffic leaves it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_gray <= '0;
      r_seen_gray <= 1'b0;
    end else if (w_b2g_xfer) begin
      r_last_gray <= out_data;
      r_seen_gray <= 1'b1;
    end
  end
`endif

endmodule
